branch_predictor_unit: RTL and testbench
========================================

Name: branch_predictor_unit

Overview:
- Successor to branch_decoder_unit: evaluates branch conditions as before and adds a direct-mapped branch history table (BHT) of saturating counters plus a branch target buffer (BTB).
- Gives the fetch stage a registered taken/target prediction. Flags a registered mispredict with a redirect PC when a branch resolves in execute.
- Sits between fetch (PC generation) and execute (register-file operands), replacing the purely combinational decoder.

Parameters:
- Width, 64, data and PC width in bits.
- Entries, 64, number of BHT/BTB entries; power of 2, >= 2.
- CounterBits, 2, width of each saturating counter; >= 1.
- TagBits, 10, width of the stored BTB tag; must satisfy TagBits <= Width-2-log2(Entries).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  a lookup is requested for fetch_pc this cycle.
- fetch_pc  in  Width  PC being fetched.
- pred_valid  out  1  registered; a prediction is presented this cycle.
- pred_taken  out  1  registered predicted direction.
- pred_target  out  Width  registered predicted target; fetch_pc+4 when not taken.
- flush  in  1  drops the lookup issued this cycle.
- resolve_valid  in  1  a branch is in execute this cycle.
- resolve_pc  in  Width  PC of the resolving instruction.
- branch_type  in  branch_t  NoBranch / Jump / CondBranch.
- cond_branch_type  in  cond_branch_t  Beq/Bne/Blt/Bge/Bltu/Bgeu.
- read_data_1  in  Width  rs1 operand.
- read_data_2  in  Width  rs2 operand.
- resolve_target  in  Width  computed target (PC or rs1, plus imm).
- resolve_pred_taken  in  1  direction predicted for this instruction.
- resolve_pred_target  in  Width  target predicted for this instruction.
- pc_src  out  pc_src_t  combinational; same semantics as branch_decoder_unit.
- mispredict  out  1  registered, single-cycle pulse.
- redirect_pc  out  Width  registered correct next PC; valid while mispredict=1.

Behaviour:
- Reset (async assert, sync release):
  - pred_valid=0, pred_taken=0, pred_target=0, mispredict=0, redirect_pc=0.
  - All counters set to weakly-not-taken (2^(CounterBits-1)-1; 1 for 2-bit).
  - All BTB valid bits cleared.
  - Reset mid-operation discards any pending prediction or mispredict.
- Index and tag:
  - index = pc[log2(Entries)+1:2].
  - tag = pc[log2(Entries)+2+TagBits-1 : log2(Entries)+2].
- Lookup, 1-cycle latency:
  - When fetch_valid=1 and flush=0 at edge N, pred_valid=1 during cycle N+1.
  - Hit = entry valid and tag equal.
  - pred_taken = hit AND counter MSB set.
  - pred_target = stored target if pred_taken, else fetch_pc+4 (mod 2^Width).
  - fetch_valid=0 or flush=1 gives pred_valid=0 next cycle. pred_taken and pred_target hold their last values in that case.
- Condition evaluation (combinational):
  - Beq/Bne compare equality.
  - Blt/Bge use signed compare; Bltu/Bgeu use unsigned compare.
  - actual_taken = 1 for Jump; cond result for CondBranch; 0 for NoBranch or resolve_valid=0.
  - pc_src = PcOrReadDataPlusImm if actual_taken, else PcPlus4.
- Update on rising edge with resolve_valid=1:
  - CondBranch: counter increments if actual_taken, else decrements. It saturates at 2^CounterBits-1 and at 0.
  - Jump: counter forced to max.
  - Taken Jump or CondBranch: entry valid=1, tag and resolve_target written.
  - Not-taken CondBranch: tag and target untouched.
  - NoBranch: no state change.
- Mispredict, registered one cycle after resolve:
  - Fires when branch_type != NoBranch and either actual_taken != resolve_pred_taken, or actual_taken=1 and resolve_target != resolve_pred_target.
  - redirect_pc = resolve_target if taken, else resolve_pc+4.
  - mispredict is a single-cycle pulse.
  - It is independent of flush; flush affects only the lookup path.
- Simultaneous lookup and update to the same index in one cycle: the lookup returns pre-update state (read-before-write). No bypass.
- Aliasing: tag mismatch is a miss and predicts not taken. A taken resolve overwrites the entry. The counter is shared per index regardless of tag.

Test Plan:
- Reset then lookup fetch_pc=0x1000 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x1004; mispredict=0.
- Resolve Beq at pc=0x1000 with rd1=rd2=5, resolve_pred_taken=0, target=0x1080 -> pc_src=PcOrReadDataPlusImm; next cycle mispredict=1, redirect_pc=0x1080. Lookup 0x1000 afterwards -> pred_taken=1 (counter 2), pred_target=0x1080.
- Three not-taken Bltu resolves at 0x1000 (rd1=7, rd2=3) -> counter saturates at 0; a fourth leaves it 0; lookup gives pred_taken=0, pred_target=0x1004.
- Blt with rd1=-1, rd2=1 -> taken; Bltu with the same operands -> not taken, pc_src=PcPlus4; mispredict follows resolve_pred_taken.
- Same-cycle lookup and taken-Jump update at 0x2000 from reset -> lookup gives pred_taken=0; the lookup one cycle later gives pred_taken=1, pred_target=resolve_target.
- fetch_valid=1 with flush=1 -> pred_valid=0 next cycle; reset_n pulsed low while mispredict=1 -> mispredict=0 immediately and all entries invalid.

Source files
------------

// File: rtl/branch_predictor_unit.sv
// Branch predictor: BHT of saturating counters plus a tagged BTB for fetch, and
// execute-stage branch resolution with registered mispredict/redirect.
package branch_predictor_unit_pkg;
   typedef enum logic [1:0] {NoBranch = 2'd0, Jump = 2'd1, CondBranch = 2'd2} branch_t;
   typedef enum logic [2:0] {Beq, Bne, Blt, Bge, Bltu, Bgeu} cond_branch_t;
   typedef enum logic {PcPlus4 = 1'b0, PcOrReadDataPlusImm = 1'b1} pc_src_t;
endpackage

module branch_predictor_unit
   import branch_predictor_unit_pkg::*;
#(
   parameter int unsigned Width       = 64,
   parameter int unsigned Entries     = 64,
   parameter int unsigned CounterBits = 2,
   parameter int unsigned TagBits     = 10
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             fetch_valid,
   input  logic [Width-1:0] fetch_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [Width-1:0] pred_target,
   input  logic             flush,
   input  logic             resolve_valid,
   input  logic [Width-1:0] resolve_pc,
   input  branch_t          branch_type,
   input  cond_branch_t     cond_branch_type,
   input  logic [Width-1:0] read_data_1,
   input  logic [Width-1:0] read_data_2,
   input  logic [Width-1:0] resolve_target,
   input  logic             resolve_pred_taken,
   input  logic [Width-1:0] resolve_pred_target,
   output pc_src_t          pc_src,
   output logic             mispredict,
   output logic [Width-1:0] redirect_pc
);
   localparam int unsigned IdxBits = $clog2(Entries);
   localparam int unsigned TagLo   = IdxBits + 2;
   localparam logic [CounterBits-1:0] CntInit = CounterBits'((1 << (CounterBits - 1)) - 1);
   localparam logic [CounterBits-1:0] CntMax  = '1;
   localparam logic [CounterBits-1:0] CntOne  = CounterBits'(1);

   logic [CounterBits-1:0] r_cnt [Entries];
   logic [Entries-1:0]     r_valid;
   logic [TagBits-1:0]     r_tag [Entries];
   logic [Width-1:0]       r_tgt [Entries];

   logic                   r_pred_valid, r_pred_taken, r_mispredict;
   logic [Width-1:0]       r_pred_target, r_redirect_pc;

   logic [IdxBits-1:0]     w_fidx, w_ridx;
   logic [TagBits-1:0]     w_ftag, w_rtag;
   logic                   w_hit, w_lookup_taken, w_lookup;
   logic                   w_cond, w_taken, w_misp, w_upd_cnt;
   logic [CounterBits-1:0] w_cnt_cur, w_cnt_next;
   logic [Width-1:0]       w_redirect;

   assign w_fidx = fetch_pc[IdxBits+1:2];
   assign w_ftag = fetch_pc[TagLo+TagBits-1:TagLo];
   assign w_ridx = resolve_pc[IdxBits+1:2];
   assign w_rtag = resolve_pc[TagLo+TagBits-1:TagLo];

   assign w_lookup       = fetch_valid && !flush;
   assign w_hit          = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
   assign w_lookup_taken = w_hit && r_cnt[w_fidx][CounterBits-1];

   // Branch condition evaluation
   always_comb begin
      w_cond = 1'b0;
      case (cond_branch_type)
         Beq:     w_cond = (read_data_1 == read_data_2);
         Bne:     w_cond = (read_data_1 != read_data_2);
         Blt:     w_cond = ($signed(read_data_1) <  $signed(read_data_2));
         Bge:     w_cond = ($signed(read_data_1) >= $signed(read_data_2));
         Bltu:    w_cond = (read_data_1 <  read_data_2);
         Bgeu:    w_cond = (read_data_1 >= read_data_2);
         default: w_cond = 1'b0;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      if (resolve_valid) begin
         case (branch_type)
            Jump:       w_taken = 1'b1;
            CondBranch: w_taken = w_cond;
            default:    w_taken = 1'b0;
         endcase
      end
   end

   assign pc_src     = w_taken ? PcOrReadDataPlusImm : PcPlus4;
   assign w_redirect = w_taken ? resolve_target : resolve_pc + Width'(4);
   assign w_misp     = resolve_valid && (branch_type != NoBranch) &&
                       ((w_taken != resolve_pred_taken) ||
                        (w_taken && (resolve_target != resolve_pred_target)));

   assign w_cnt_cur = r_cnt[w_ridx];
   assign w_upd_cnt = resolve_valid && ((branch_type == Jump) || (branch_type == CondBranch));

   // Saturating counter next value; jumps pin the counter at max
   always_comb begin
      w_cnt_next = w_cnt_cur;
      if (branch_type == Jump) begin
         w_cnt_next = CntMax;
      end else if (w_taken) begin
         if (w_cnt_cur != CntMax) w_cnt_next = w_cnt_cur + CntOne;
      end else begin
         if (w_cnt_cur != '0) w_cnt_next = w_cnt_cur - CntOne;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pred_valid  <= 1'b0;
         r_pred_taken  <= 1'b0;
         r_pred_target <= '0;
         r_mispredict  <= 1'b0;
         r_redirect_pc <= '0;
         r_valid       <= '0;
         for (int i = 0; i < Entries; i++) r_cnt[i] <= CntInit;
      end else begin
         r_pred_valid <= w_lookup;
         if (w_lookup) begin
            r_pred_taken  <= w_lookup_taken;
            r_pred_target <= w_lookup_taken ? r_tgt[w_fidx] : fetch_pc + Width'(4);
         end
         r_mispredict <= w_misp;
         if (w_misp) r_redirect_pc <= w_redirect;
         if (w_upd_cnt) r_cnt[w_ridx] <= w_cnt_next;
         if (w_taken) r_valid[w_ridx] <= 1'b1;
      end
   end

   // Tag/target payload is qualified by r_valid, so it needs no reset
   always_ff @(posedge clock) begin
      if (w_taken) begin
         r_tag[w_ridx] <= w_rtag;
         r_tgt[w_ridx] <= resolve_target;
      end
   end

   assign pred_valid  = r_pred_valid;
   assign pred_taken  = r_pred_taken;
   assign pred_target = r_pred_target;
   assign mispredict  = r_mispredict;
   assign redirect_pc = r_redirect_pc;
endmodule

// File: tb/tb_branch_predictor_unit.sv
// Scoreboard bench for branch_predictor_unit: a reference model pushes expected
// lookup/mispredict results per cycle; they are popped and compared after the edge.
module tb_branch_predictor_unit;
   import branch_predictor_unit_pkg::*;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         fetch_valid, flush, resolve_valid, resolve_pred_taken;
   logic [63:0]  fetch_pc, resolve_pc, read_data_1, read_data_2;
   logic [63:0]  resolve_target, resolve_pred_target;
   branch_t      branch_type;
   cond_branch_t cond_branch_type;
   logic         pred_valid, pred_taken, mispredict;
   logic [63:0]  pred_target, redirect_pc;
   pc_src_t      pc_src;

   always #5 clock = ~clock;

   branch_predictor_unit dut (
      .clock(clock), .reset_n(reset_n),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
      .flush(flush), .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
      .branch_type(branch_type), .cond_branch_type(cond_branch_type),
      .read_data_1(read_data_1), .read_data_2(read_data_2),
      .resolve_target(resolve_target), .resolve_pred_taken(resolve_pred_taken),
      .resolve_pred_target(resolve_pred_target), .pc_src(pc_src),
      .mispredict(mispredict), .redirect_pc(redirect_pc)
   );

   typedef struct {
      logic        pv;
      logic        pt;
      logic [63:0] ptgt;
      logic        mp;
      logic [63:0] rpc;
   } exp_t;

   exp_t        q_exp[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   int          m_cnt [64];
   bit          m_val [64];
   logic [9:0]  m_tag [64];
   logic [63:0] m_tgt [64];
   logic        e_pt;
   logic [63:0] e_ptgt, e_redir;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         m_cnt[i] = 1;
         m_val[i] = 1'b0;
      end
      e_pt    = 1'b0;
      e_ptgt  = '0;
      e_redir = '0;
   endtask

   function automatic logic eval_taken(input logic rv, input branch_t bt, input cond_branch_t ct,
                                       input logic [63:0] a, input logic [63:0] b);
      if (!rv || bt == NoBranch) return 1'b0;
      if (bt == Jump) return 1'b1;
      case (ct)
         Beq:  return a == b;
         Bne:  return a != b;
         Blt:  return $signed(a) <  $signed(b);
         Bge:  return $signed(a) >= $signed(b);
         Bltu: return a <  b;
         Bgeu: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive_idle();
      fetch_valid = 0; fetch_pc = '0; flush = 0; resolve_valid = 0; resolve_pc = '0;
      branch_type = NoBranch; cond_branch_type = Beq; read_data_1 = '0; read_data_2 = '0;
      resolve_target = '0; resolve_pred_taken = 0; resolve_pred_target = '0;
   endtask

   task automatic step(input logic fv, input logic [63:0] fpc, input logic fl,
                       input logic rv, input logic [63:0] rpc, input branch_t bt,
                       input cond_branch_t ct, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] rt, input logic rpt, input logic [63:0] rptgt);
      exp_t e;
      logic tk;
      int   fi, ri;
      @(negedge clock);
      fetch_valid = fv; fetch_pc = fpc; flush = fl; resolve_valid = rv; resolve_pc = rpc;
      branch_type = bt; cond_branch_type = ct; read_data_1 = a; read_data_2 = b;
      resolve_target = rt; resolve_pred_taken = rpt; resolve_pred_target = rptgt;
      #1;
      tk = eval_taken(rv, bt, ct, a, b);
      check("pc_src", 64'(pc_src), 64'(tk));
      fi   = int'(fpc[7:2]);
      e.pv = fv && !fl;
      if (e.pv) begin
         e_pt   = m_val[fi] && (m_tag[fi] == fpc[17:8]) && (m_cnt[fi] >= 2);
         e_ptgt = e_pt ? m_tgt[fi] : fpc + 64'd4;
      end
      e.pt   = e_pt;
      e.ptgt = e_ptgt;
      e.mp   = rv && (bt != NoBranch) && ((tk != rpt) || (tk && (rt != rptgt)));
      if (e.mp) e_redir = tk ? rt : rpc + 64'd4;
      e.rpc = e_redir;
      q_exp.push_back(e);
      ri = int'(rpc[7:2]);
      if (rv && bt == Jump) m_cnt[ri] = 3;
      else if (rv && bt == CondBranch)
         m_cnt[ri] = tk ? ((m_cnt[ri] == 3) ? 3 : m_cnt[ri] + 1) : ((m_cnt[ri] == 0) ? 0 : m_cnt[ri] - 1);
      if (tk) begin
         m_val[ri] = 1'b1;
         m_tag[ri] = rpc[17:8];
         m_tgt[ri] = rt;
      end
      @(posedge clock);
      #1;
      if (q_exp.size() == 0) begin
         check("scoreboard_empty", 64'd0, 64'd1);
      end else begin
         e = q_exp.pop_front();
         check("pred_valid", 64'(pred_valid), 64'(e.pv));
         check("pred_taken", 64'(pred_taken), 64'(e.pt));
         check("pred_target", pred_target, e.ptgt);
         check("mispredict", 64'(mispredict), 64'(e.mp));
         check("redirect_pc", redirect_pc, e.rpc);
      end
   endtask

   task automatic lookup(input logic [63:0] pc);
      step(1, pc, 0, 0, '0, NoBranch, Beq, '0, '0, '0, 0, '0);
   endtask

   task automatic resolve(input logic [63:0] pc, input branch_t bt, input cond_branch_t ct,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] rt,
                          input logic rpt, input logic [63:0] rptgt);
      step(0, '0, 0, 1, pc, bt, ct, a, b, rt, rpt, rptgt);
   endtask

   initial begin
      logic [63:0] pcs [4];
      logic [63:0] rt, rpc, a, b;
      pcs[0] = 64'h1000; pcs[1] = 64'h2000; pcs[2] = 64'h1044; pcs[3] = 64'h3000;
      drive_idle();
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("rst_pred_valid", 64'(pred_valid), 64'd0);
      check("rst_pred_taken", 64'(pred_taken), 64'd0);
      check("rst_pred_target", pred_target, 64'd0);
      check("rst_mispredict", 64'(mispredict), 64'd0);
      check("rst_redirect", redirect_pc, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      lookup(64'h1000);
      resolve(64'h1000, CondBranch, Beq, 64'd5, 64'd5, 64'h1080, 0, 64'h0);
      lookup(64'h1000);
      resolve(64'h1000, CondBranch, Bltu, 64'd7, 64'd3, 64'h1080, 1, 64'h1080);
      repeat (3) resolve(64'h1000, CondBranch, Bltu, 64'd7, 64'd3, 64'h1080, 0, 64'h0);
      lookup(64'h1000);
      resolve(64'h3000, CondBranch, Blt, '1, 64'd1, 64'h3100, 0, 64'h0);
      resolve(64'h3000, CondBranch, Bltu, '1, 64'd1, 64'h3100, 1, 64'h3100);
      resolve(64'h3000, CondBranch, Bge, 64'd4, 64'd4, 64'h3200, 1, 64'h3100);
      step(1, 64'h2000, 0, 1, 64'h2000, Jump, Beq, '0, '0, 64'h2400, 0, '0);
      lookup(64'h2000);
      lookup(64'h1000);
      step(1, 64'h2000, 1, 0, '0, NoBranch, Beq, '0, '0, '0, 0, '0);
      resolve(64'h2000, NoBranch, Beq, 64'd1, 64'd1, 64'h9000, 1, 64'h0);
      resolve(64'h1044, CondBranch, Bgeu, 64'd9, 64'd2, 64'h1500, 1, 64'h1500);
      lookup(64'h1044);

      for (int i = 0; i < 40; i++) begin
         rpc = pcs[$urandom_range(0, 3)];
         rt  = 64'h4000 + 64'($urandom_range(0, 15)) * 64'd16;
         a   = ($urandom_range(0, 1) != 0) ? -64'($urandom_range(1, 3)) : 64'($urandom_range(0, 3));
         b   = 64'($urandom_range(0, 3));
         step(1'($urandom_range(0, 1)), pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), rpc, branch_t'($urandom_range(0, 2)),
              cond_branch_t'($urandom_range(0, 5)), a, b, rt, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) != 0) ? rt : rt + 64'd16);
      end

      resolve(64'h2000, Jump, Beq, '0, '0, 64'h2800, 0, '0);
      check("pre_rst_misp", 64'(mispredict), 64'd1);
      drive_idle();
      reset_n = 1'b0;
      #1;
      check("rst_mid_misp", 64'(mispredict), 64'd0);
      check("rst_mid_redirect", redirect_pc, 64'd0);
      check("rst_mid_pred_target", pred_target, 64'd0);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      lookup(64'h2000);
      lookup(64'h1044);
      lookup(64'h3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
